// File: rtl/gmii_frame_tx.sv
// gmii_frame_tx: frames a valid/ready byte stream as preamble, SFD, payload, pad and 16-bit additive checksum
module gmii_frame_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 46,
  parameter int IFG_LEN      = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       err_underrun
);
  localparam int CMAX = PREAMBLE_LEN > IFG_LEN ? PREAMBLE_LEN : IFG_LEN;
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = $clog2(MIN_PAYLOAD + 1);
  typedef enum logic [3:0] {IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS_LO, FCS_HI, DRAIN, IFG} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [15:0] sum, sum_n;
  logic done, done_n;
  logic [7:0] txd_n;
  logic tx_en_n, err_n;
  logic pmin;
  assign s_ready = state == SFD || state == DRAIN || (state == PAYLOAD && !done);
  assign pmin = pcnt == PW'(MIN_PAYLOAD);
  // state and every output register, so txd/tx_en always line up with the state presenting them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pcnt <= '0;
      sum <= '0;
      done <= 1'b0;
      txd <= 8'h00;
      tx_en <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pcnt <= pcnt_n;
      sum <= sum_n;
      done <= done_n;
      txd <= txd_n;
      tx_en <= tx_en_n;
      err_underrun <= err_n;
    end
  end
  // next state and the byte to present next cycle; done marks PAYLOAD showing the s_last byte
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pcnt_n = pcnt;
    sum_n = sum;
    done_n = done;
    txd_n = 8'h00;
    tx_en_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (s_valid) begin
        state_n = PREAMBLE;
        cnt_n = CW'(1);
        pcnt_n = '0;
        sum_n = '0;
        done_n = 1'b0;
        txd_n = 8'h55;
        tx_en_n = 1'b1;
      end
      PREAMBLE: begin
        tx_en_n = 1'b1;
        state_n = cnt == CW'(PREAMBLE_LEN) ? SFD : PREAMBLE;
        txd_n = cnt == CW'(PREAMBLE_LEN) ? 8'hD5 : 8'h55;
        cnt_n = cnt + CW'(1);
      end
      SFD, PAYLOAD: begin
        if (state == PAYLOAD && done) begin
          tx_en_n = 1'b1;
          state_n = pmin ? FCS_LO : PAD;
          txd_n = pmin ? sum[7:0] : 8'h00;
          pcnt_n = pmin ? pcnt : pcnt + PW'(1);
        end else if (s_valid) begin
          state_n = PAYLOAD;
          txd_n = s_data;
          tx_en_n = 1'b1;
          sum_n = sum + {8'h00, s_data};
          pcnt_n = pmin ? pcnt : pcnt + PW'(1);
          done_n = s_last;
        end else begin
          state_n = DRAIN;
          err_n = 1'b1;
        end
      end
      PAD: begin
        tx_en_n = 1'b1;
        state_n = pmin ? FCS_LO : PAD;
        txd_n = pmin ? sum[7:0] : 8'h00;
        pcnt_n = pmin ? pcnt : pcnt + PW'(1);
      end
      FCS_LO: begin
        state_n = FCS_HI;
        txd_n = sum[15:8];
        tx_en_n = 1'b1;
      end
      FCS_HI: begin
        state_n = IFG;
        cnt_n = CW'(1);
      end
      DRAIN: if (s_valid && s_last) begin
        state_n = IFG;
        cnt_n = CW'(1);
      end
      IFG: begin
        state_n = cnt == CW'(IFG_LEN) ? IDLE : IFG;
        cnt_n = cnt + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/gmii_frame_tx.md
# gmii_frame_tx

Byte-stream frame transmitter that builds the `rxd`/`rx_dv` traffic consumed by the byte-pipe DUT.
- Accepts payload bytes on a valid/ready source interface.
- Emits each frame as preamble, SFD, payload, zero padding to a minimum length, then a 16-bit additive checksum.
- Enforces a minimum inter-frame gap and aborts cleanly on source underrun.
- Sits between the bench/driver-side packet source and the DUT receive port.

## Interface
- `PREAMBLE_LEN`, default 7: number of 0x55 preamble bytes; must be ≥1.
- `MIN_PAYLOAD`, default 46: minimum payload bytes per frame, with padding included; must be ≥1.
- `IFG_LEN`, default 12: minimum idle cycles (`tx_en`=0) between frames; must be ≥1.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  8  payload byte.
- `s_valid`  in  1  `s_data`/`s_last` valid.
- `s_last`  in  1  current byte is the final payload byte of the frame.
- `s_ready`  out  1  block accepts the byte this cycle; a handshake is `s_valid && s_ready`.
- `txd`  out  8  transmit byte; registered.
- `tx_en`  out  1  `txd` carries frame data; registered.
- `err_underrun`  out  1  one-cycle pulse when a frame is aborted; registered.

## Operation
- States: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS_LO, FCS_HI, DRAIN, IFG.
- **IDLE**
  - `s_ready`=0.
  - `s_valid`=1 starts a frame. The source byte is held, not consumed.
- **PREAMBLE**
  - Outputs `PREAMBLE_LEN` bytes of 0x55.
- **SFD**
  - Outputs a single 0xD5.
  - `s_ready`=1 in the cycle `txd`=0xD5 is presented, so the first payload byte can follow with no bubble.
- **PAYLOAD**
  - Each handshake puts `s_data` on `txd` the next cycle, with `tx_en`=1.
  - `s_ready` stays 1 through the `s_last` handshake, then drops.
  - Payload counter saturates at `MIN_PAYLOAD`.
  - Checksum = sum of all payload bytes mod 2^16. It is cleared at frame start.
- **PAD**
  - Entered after `s_last` if the payload count is below `MIN_PAYLOAD`.
  - Outputs 0x00 bytes until transmitted payload plus pad equals `MIN_PAYLOAD`.
  - Pad bytes add 0 to the checksum.
  - A frame of exactly `MIN_PAYLOAD` bytes or more gets no pad.
- **FCS_LO / FCS_HI**
  - Output checksum[7:0], then checksum[15:8].
  - No maximum frame length.
- **Underrun**
  - Trigger: in PAYLOAD, `s_ready`=1 and `s_valid`=0 in any cycle before the `s_last` handshake.
  - Next cycle: `tx_en`=0, `txd`=0x00, `err_underrun`=1 for exactly one cycle. No pad or FCS is sent.
  - Then DRAIN: `s_ready`=1 and accepted bytes are discarded up to and including the `s_last` handshake, with `tx_en`=0 throughout. If that handshake occurs in the same cycle DRAIN is entered, DRAIN lasts one cycle.
  - Then IFG.
- **IFG**
  - `IFG_LEN` cycles of `tx_en`=0 and `s_ready`=0, then IDLE.
- Whenever `tx_en`=0, `txd`=0x00.
- **Reset (any time, including mid-frame)**
  - Asynchronously forces `txd`=0x00, `tx_en`=0, `err_underrun`=0, `s_ready`=0, and state IDLE.
  - Clears counters and checksum.
  - No IFG is imposed after reset release.
  - The source must restart its frame from the first byte.

## Timing
- Cycle T: IDLE with `s_valid`=1.
- T+1 … T+`PREAMBLE_LEN`: `txd`=0x55, `tx_en`=1.
- T+`PREAMBLE_LEN`+1: `txd`=0xD5, `s_ready`=1.
- First payload byte on `txd` at T+`PREAMBLE_LEN`+2 when the source is valid at SFD.
- Payload latency: 1 cycle from handshake to `txd`.
- `tx_en` is contiguous from the first preamble byte to FCS_HI. It drops only on underrun.
- The cycle after FCS_HI starts IFG (`tx_en`=0). The earliest next preamble byte is IFG_LEN+2 cycles after FCS_HI, because IDLE must sample `s_valid`.
- Frame length in `tx_en`-high cycles = `PREAMBLE_LEN`+1+max(N,`MIN_PAYLOAD`)+2.
- `s_ready` is a function of registered state only. There is no combinational path from `s_valid`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-payload, asynchronously to `clk`. Required response:
  - `txd`=0x00, `tx_en`=0, `s_ready`=0 immediately.
  - After release, a new frame starts cleanly and its checksum excludes pre-reset bytes.
- **Single byte 0xA5:** required response:
  - 7×0x55, 0xD5, 0xA5, 45×0x00, 0xA5, 0x00.
  - `tx_en` high 56 contiguous cycles.
- **46 bytes 0x01…0x2E, source always valid:** required response:
  - No pad; sum=0x0439, so FCS bytes are 0x39 then 0x04.
  - 56 `tx_en` cycles with no bubbles.
- **60 bytes of 0xFF:** required response:
  - No pad; sum=15300=0x3BC4, so FCS bytes are 0xC4 then 0x3B.
  - `tx_en` high 70 cycles.
- **Two frames back-to-back, second `s_valid` held high throughout:** required response:
  - Exactly 13 `tx_en`=0 cycles between the first frame's 0x3B/last FCS byte and the second frame's first 0x55.
  - Checksum restarts at 0 for the second frame.
- **Underrun:** drop `s_valid` for one cycle after byte 10 of a 20-byte frame. Required response:
  - Next cycle `tx_en`=0 and `err_underrun` pulses once.
  - Bytes 11–20 are accepted with `tx_en`=0.
  - The following frame's preamble starts no earlier than IFG_LEN+1 cycles after the DRAIN `s_last` handshake.
